// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the ID/EX hazard controller: register widths, FSM encodings, defaults.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_W          = 5;
  localparam int unsigned MD_LATENCY_DEF = 4;
  localparam int unsigned CNT_W_DEF      = 16;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  // Legacy-compatible state encodings
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] MD_RUN = 1'b1;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/execute-side hazard signals exchanged between the pipeline datapath and the controller.
interface pipeline_hazard_ctrl_if
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic [REG_W-1:0] ID_rs;
  logic [REG_W-1:0] ID_rt;
  logic             ID_UsesRt;
  logic             ID_MD;
  logic             ID_MDRead;
  logic             ID_Jump;
  logic             EX_MemRd;
  logic [REG_W-1:0] EX_WrReg;
  logic             EX_BrTaken;

  logic             PC_hold;
  logic             IFID_hold;
  logic             IFID_flush;
  logic             IDEX_stall;
  logic             MD_start;
  logic             MD_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ID_rs, ID_rt, ID_UsesRt, ID_MD, ID_MDRead, ID_Jump,
           EX_MemRd, EX_WrReg, EX_BrTaken,
    input  PC_hold, IFID_hold, IFID_flush, IDEX_stall, MD_start, MD_busy, stall_cnt
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UsesRt, ID_MD, ID_MDRead, ID_Jump,
           EX_MemRd, EX_WrReg, EX_BrTaken,
    output PC_hold, IFID_hold, IFID_flush, IDEX_stall, MD_start, MD_busy, stall_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_md_busy_counter.sv
// Countdown for the mult/div busy window; zero_c marks the final busy cycle.
module md_busy_counter #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero_c
);

  localparam int unsigned CW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(MD_LATENCY - 1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch / jump / mult-div hazard sequencing for the ID/EX register and front end.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  pipeline_hazard_ctrl_if.slave        hz
);

  logic [0:0]       state_d;
  logic [0:0]       state_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic lu;
  logic mdst;
  logic md_busy;
  logic md_zero;
  logic pc_hold;
  logic ifid_hold;
  logic ifid_flush;
  logic idex_stall;
  logic md_start;

  assign md_busy = (state_q == MD_RUN);

  assign lu = hz.EX_MemRd && (hz.EX_WrReg != REG_ZERO) &&
              ((hz.EX_WrReg == hz.ID_rs) || (hz.ID_UsesRt && (hz.EX_WrReg == hz.ID_rt)));

  // HI/LO readers are released in the last busy cycle; a new mult/div waits for IDLE
  assign mdst = md_busy && (hz.ID_MD || (hz.ID_MDRead && !md_zero));

  always_comb begin
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    idex_stall = 1'b0;
    md_start   = 1'b0;
    if (!reset) begin
      if (hz.EX_BrTaken) begin
        ifid_flush = 1'b1;
        idex_stall = 1'b1;
      end else if (lu || mdst) begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_stall = 1'b1;
      end else if (hz.ID_Jump) begin
        ifid_flush = 1'b1;
      end else begin
        md_start = hz.ID_MD && (state_q == IDLE);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (md_start) state_d = MD_RUN;
      MD_RUN:  if (md_zero)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (idex_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  md_busy_counter #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (md_start),
    .dec    (md_busy),
    .zero_c (md_zero)
  );

  assign hz.PC_hold    = pc_hold;
  assign hz.IFID_hold  = ifid_hold;
  assign hz.IFID_flush = ifid_flush;
  assign hz.IDEX_stall = idex_stall;
  assign hz.MD_start   = md_start;
  assign hz.MD_busy    = md_busy;
  assign hz.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed checks of hazard priority, mult/div busy window, reset and stall counter saturation.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   exp_cnt;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hz ();
  pipeline_hazard_ctrl_if #(.CNT_W(3))  sif ();

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(3)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .hz    (sif)
  );

  // {PC_hold, IFID_hold, IFID_flush, IDEX_stall, MD_start, MD_busy}
  logic [5:0] ctl;
  assign ctl = {hz.PC_hold, hz.IFID_hold, hz.IFID_flush, hz.IDEX_stall, hz.MD_start, hz.MD_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    hz.ID_rs      = '0;
    hz.ID_rt      = '0;
    hz.ID_UsesRt  = 1'b0;
    hz.ID_MD      = 1'b0;
    hz.ID_MDRead  = 1'b0;
    hz.ID_Jump    = 1'b0;
    hz.EX_MemRd   = 1'b0;
    hz.EX_WrReg   = '0;
    hz.EX_BrTaken = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    hz.ID_MD = 1'b1; hz.ID_Jump = 1'b1; hz.EX_BrTaken = 1'b1;
    hz.EX_MemRd = 1'b1; hz.EX_WrReg = 5'd8; hz.ID_rs = 5'd8;
    #12;
    tests++;
    if (ctl !== 6'b000000) begin
      fails++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 6'b000000);
    end
    tests++;
    if (hz.stall_cnt !== 16'd0) begin
      fails++; $display("FAIL reset_cnt got=%0d exp=0", hz.stall_cnt);
    end
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    hz.EX_MemRd = 1'b1; hz.EX_WrReg = 5'd8; hz.ID_rs = 5'd8; hz.ID_rt = 5'd3;
    #1;
    tests++;
    if (ctl !== 6'b110100) begin
      fails++; $display("FAIL lu_rs_ctl got=%b exp=%b", ctl, 6'b110100);
    end
    @(posedge clk); #1;
    exp_cnt++;
    tests++;
    if (hz.stall_cnt !== 16'(exp_cnt)) begin
      fails++; $display("FAIL lu_rs_cnt got=%0d exp=%0d", hz.stall_cnt, exp_cnt);
    end
    @(negedge clk);
    hz.EX_WrReg = 5'd0; hz.ID_rs = 5'd0;
    #1;
    tests++;
    if (ctl !== 6'b000000) begin
      fails++; $display("FAIL lu_r0_ctl got=%b exp=%b", ctl, 6'b000000);
    end
    @(posedge clk); #1;
    tests++;
    if (hz.stall_cnt !== 16'(exp_cnt)) begin
      fails++; $display("FAIL lu_r0_cnt got=%0d exp=%0d", hz.stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_rt_gating();
    @(negedge clk);
    clear_inputs();
    hz.EX_MemRd = 1'b1; hz.EX_WrReg = 5'd9; hz.ID_rt = 5'd9; hz.ID_rs = 5'd4;
    #1;
    tests++;
    if (ctl !== 6'b000000) begin
      fails++; $display("FAIL rt_unused_ctl got=%b exp=%b", ctl, 6'b000000);
    end
    @(negedge clk);
    hz.ID_UsesRt = 1'b1;
    #1;
    tests++;
    if (ctl !== 6'b110100) begin
      fails++; $display("FAIL rt_used_ctl got=%b exp=%b", ctl, 6'b110100);
    end
    @(posedge clk); #1;
    exp_cnt++;
    tests++;
    if (hz.stall_cnt !== 16'(exp_cnt)) begin
      fails++; $display("FAIL rt_used_cnt got=%0d exp=%0d", hz.stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_mult_mflo();
    logic [5:0] exp;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      clear_inputs();
      hz.ID_MD     = (c == 0);
      hz.ID_MDRead = (c >= 1 && c <= 4);
      if (c == 0)       exp = 6'b000010;
      else if (c <= 3)  exp = 6'b110101;
      else if (c == 4)  exp = 6'b000001;
      else              exp = 6'b000000;
      #1;
      tests++;
      if (ctl !== exp) begin
        fails++; $display("FAIL md_cycle%0d_ctl got=%b exp=%b", c, ctl, exp);
      end
      if (exp[2]) exp_cnt++;
    end
    @(posedge clk); #1;
    tests++;
    if (hz.stall_cnt !== 16'(exp_cnt)) begin
      fails++; $display("FAIL md_cnt got=%0d exp=%0d", hz.stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_branch_priority();
    @(negedge clk);
    clear_inputs();
    hz.EX_BrTaken = 1'b1; hz.EX_MemRd = 1'b1; hz.EX_WrReg = 5'd8; hz.ID_rs = 5'd8;
    hz.ID_MD = 1'b1;
    #1;
    tests++;
    if (ctl !== 6'b001100) begin
      fails++; $display("FAIL br_lu_ctl got=%b exp=%b", ctl, 6'b001100);
    end
    exp_cnt++;
    @(negedge clk);
    clear_inputs();
    #1;
    tests++;
    if (ctl !== 6'b000000) begin
      fails++; $display("FAIL br_no_md_ctl got=%b exp=%b", ctl, 6'b000000);
    end
    @(negedge clk);
    hz.ID_Jump = 1'b1;
    #1;
    tests++;
    if (ctl !== 6'b001000) begin
      fails++; $display("FAIL jump_ctl got=%b exp=%b", ctl, 6'b001000);
    end
    @(posedge clk); #1;
    tests++;
    if (hz.stall_cnt !== 16'(exp_cnt)) begin
      fails++; $display("FAIL br_cnt got=%0d exp=%0d", hz.stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_branch_in_md();
    logic [5:0] exp;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      clear_inputs();
      hz.ID_MD      = (c == 0);
      hz.EX_BrTaken = (c == 1);
      if (c == 0)       exp = 6'b000010;
      else if (c == 1)  exp = 6'b001101;
      else if (c <= 4)  exp = 6'b000001;
      else              exp = 6'b000000;
      #1;
      tests++;
      if (ctl !== exp) begin
        fails++; $display("FAIL br_md_cycle%0d_ctl got=%b exp=%b", c, ctl, exp);
      end
      if (exp[2]) exp_cnt++;
    end
  endtask

  task automatic test_reset_mid_md();
    @(negedge clk);
    clear_inputs();
    hz.ID_MD = 1'b1;
    @(negedge clk);
    hz.ID_MD = 1'b0;
    @(negedge clk);
    hz.ID_MDRead = 1'b1;
    #1;
    tests++;
    if (ctl !== 6'b110101) begin
      fails++; $display("FAIL pre_rst_ctl got=%b exp=%b", ctl, 6'b110101);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (ctl !== 6'b000000) begin
      fails++; $display("FAIL async_rst_ctl got=%b exp=%b", ctl, 6'b000000);
    end
    tests++;
    if (hz.stall_cnt !== 16'd0) begin
      fails++; $display("FAIL async_rst_cnt got=%0d exp=0", hz.stall_cnt);
    end
    exp_cnt = 0;
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    hz.ID_MD = 1'b1;
    #1;
    tests++;
    if (ctl !== 6'b000010) begin
      fails++; $display("FAIL post_rst_idle_ctl got=%b exp=%b", ctl, 6'b000010);
    end
    @(negedge clk);
    clear_inputs();
    repeat (5) @(negedge clk);
    #1;
    tests++;
    if (ctl !== 6'b000000) begin
      fails++; $display("FAIL post_rst_done_ctl got=%b exp=%b", ctl, 6'b000000);
    end
  endtask

  task automatic test_saturation();
    int exp;
    @(negedge clk);
    sif.EX_MemRd = 1'b1; sif.EX_WrReg = 5'd5; sif.ID_rs = 5'd5;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      exp = (k < 7) ? k : 7;
      tests++;
      if (sif.stall_cnt !== 3'(exp)) begin
        fails++; $display("FAIL sat_cycle%0d_cnt got=%0d exp=%0d", k, sif.stall_cnt, exp);
      end
    end
    @(negedge clk);
    sif.EX_MemRd = 1'b0; sif.EX_WrReg = '0; sif.ID_rs = '0;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    exp_cnt = 0;
    sif.ID_rs = '0; sif.ID_rt = '0; sif.ID_UsesRt = 1'b0; sif.ID_MD = 1'b0;
    sif.ID_MDRead = 1'b0; sif.ID_Jump = 1'b0; sif.EX_MemRd = 1'b0;
    sif.EX_WrReg = '0; sif.EX_BrTaken = 1'b0;
    test_reset();
    test_load_use();
    test_rt_gating();
    test_mult_mflo();
    test_branch_priority();
    test_branch_in_md();
    test_reset_mid_md();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
